// File: rtl/ttfir_pkg.sv
// Shared types and width/narrowing helpers for the ttfir_prog FIR filter.
// Optional build macro: FIR_SAT_EN (saturating output narrowing instead of wrap).
package ttfir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Working width for the narrowing helper; must cover BW_ACC.
  localparam int unsigned NARROW_W = 32;

  // Accumulator width that holds the full N-tap sum of products without overflow.
  function automatic int unsigned acc_width(input int unsigned n_taps,
                                            input int unsigned bw_in,
                                            input int unsigned bw_coef);
    return bw_in + bw_coef + $clog2(n_taps);
  endfunction

  // Narrow a sign-extended value to bw_out bits: saturate or wrap.
  function automatic logic signed [NARROW_W-1:0] narrow(input logic signed [NARROW_W-1:0] s,
                                                        input int unsigned bw_out);
    logic signed [NARROW_W-1:0] r;
`ifdef FIR_SAT_EN
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    hi = $signed((NARROW_W'(1) << (bw_out - 1)) - NARROW_W'(1));
    lo = ~hi;
    r  = (s > hi) ? hi : ((s < lo) ? lo : s);
`else
    r = (s <<< (NARROW_W - bw_out)) >>> (NARROW_W - bw_out);
`endif
    return r;
  endfunction

endpackage

// File: rtl/ttfir_coef_bank.sv
// Coefficient shift chain with load counter; first word loaded ends in h[0].
module ttfir_coef_bank
  import ttfir_pkg::*;
#(
  parameter int unsigned N_TAPS  = 5,
  parameter int unsigned BW_COEF = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_shift,
  input  logic                             i_start,
  input  logic [BW_COEF-1:0]               i_coef,
  output logic [N_TAPS-1:0][BW_COEF-1:0]   o_h,
  output logic                             o_last_c,
  output logic                             o_done
);

  localparam int unsigned CNT_W = $clog2(N_TAPS + 1);

  logic [N_TAPS-1:0][BW_COEF-1:0] r_h;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_next;
  logic                           r_done;

  // Count restarts at one on the first word of a new load sequence.
  always_comb begin
    w_cnt_next = i_start ? CNT_W'(1) : (r_cnt + CNT_W'(1));
    o_last_c   = i_shift && (w_cnt_next == CNT_W'(N_TAPS));
  end

  // Shift chain, word counter and done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_shift) begin
      r_h    <= {i_coef, r_h[N_TAPS-1:1]};
      r_cnt  <= w_cnt_next;
      r_done <= o_last_c;
    end
  end

  assign o_h    = r_h;
  assign o_done = r_done;

endmodule

// File: rtl/ttfir_prog.sv
// Runtime-programmable N-tap FIR with load/run control and registered output.
// Optional build macro: FIR_SAT_EN (saturate instead of wrap when narrowing).
module ttfir_prog
  import ttfir_pkg::*;
#(
  parameter int unsigned N_TAPS  = 5,
  parameter int unsigned BW_IN   = 6,
  parameter int unsigned BW_COEF = 4,
  parameter int unsigned BW_OUT  = 8,
  parameter int unsigned SHIFT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [BW_COEF-1:0] coef_in,
  input  logic               in_valid,
  input  logic [BW_IN-1:0]   x_in,
  output logic               coef_ready,
  output logic               y_valid,
  output logic [BW_OUT-1:0]  y_out
);

  localparam int unsigned BW_ACC = acc_width(N_TAPS, BW_IN, BW_COEF);

  state_e                         r_state;
  state_e                         w_state_nxt;
  logic                           w_shift;
  logic                           w_start;
  logic                           w_accept;
  logic                           w_last;
  logic                           w_done;
  logic [N_TAPS-1:0][BW_COEF-1:0] w_h;
  logic [N_TAPS-2:0][BW_IN-1:0]   r_dl;
  logic [N_TAPS-1:0][BW_IN-1:0]   w_taps;
  logic signed [BW_ACC-1:0]       w_acc;
  logic [BW_OUT-1:0]              w_y_nxt;
  logic                           r_y_valid;
  logic [BW_OUT-1:0]              r_y_out;

  ttfir_coef_bank #(
    .N_TAPS  (N_TAPS),
    .BW_COEF (BW_COEF)
  ) u_coef_bank (
    .clk      (clk),
    .rst      (rst),
    .i_shift  (w_shift),
    .i_start  (w_start),
    .i_coef   (coef_in),
    .o_h      (w_h),
    .o_last_c (w_last),
    .o_done   (w_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (load_en) w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_last)  w_state_nxt = ST_RUN;
      ST_RUN:  if (load_en) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM control strobes; a load request always beats a sample in RUN.
  always_comb begin
    w_shift  = 1'b0;
    w_start  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_shift = load_en;
        w_start = load_en;
      end
      ST_LOAD: w_shift = load_en;
      ST_RUN: begin
        w_shift  = load_en;
        w_start  = load_en;
        w_accept = in_valid && !load_en;
      end
      default: ;
    endcase
  end

  // Sample history; cleared whenever a new coefficient set starts loading.
  always_ff @(posedge clk) begin
    if (!rst || w_start) begin
      r_dl <= '0;
    end else if (w_accept) begin
      r_dl[0] <= x_in;
      for (int k = 1; k < int'(N_TAPS) - 1; k++) r_dl[k] <= r_dl[k-1];
    end
  end

  // Tap operands: current sample feeds h[0], history feeds the rest.
  always_comb begin
    w_taps[0] = x_in;
    for (int k = 1; k < int'(N_TAPS); k++) w_taps[k] = r_dl[k-1];
  end

  // Multiply-accumulate and output narrowing.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < int'(N_TAPS); k++) begin
      w_acc = w_acc + BW_ACC'($signed(w_h[k])) * BW_ACC'($signed(w_taps[k]));
    end
    w_y_nxt = BW_OUT'(narrow(NARROW_W'(w_acc >>> SHIFT), BW_OUT));
  end

  // Registered result; y_out holds between accepted samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y_valid <= 1'b0;
      r_y_out   <= '0;
    end else begin
      r_y_valid <= w_accept;
      if (w_accept) r_y_out <= w_y_nxt;
    end
  end

  assign coef_ready = w_done;
  assign y_valid    = r_y_valid;
  assign y_out      = r_y_out;

endmodule

// File: tb/tb_ttfir_prog.sv
// Bench for ttfir_prog: directed vector table plus randomized run against a reference model.
module tb_ttfir_prog;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [3:0] coef_in;
  logic       in_valid;
  logic [5:0] x_in;
  logic       rdy0, v0, rdy2, v2;
  logic [7:0] y0, y2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ttfir_prog #(.N_TAPS(5), .BW_IN(6), .BW_COEF(4), .BW_OUT(8), .SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .load_en(load_en), .coef_in(coef_in), .in_valid(in_valid),
    .x_in(x_in), .coef_ready(rdy0), .y_valid(v0), .y_out(y0));

  ttfir_prog #(.N_TAPS(5), .BW_IN(6), .BW_COEF(4), .BW_OUT(8), .SHIFT(2)) u_s2 (
    .clk(clk), .rst(rst), .load_en(load_en), .coef_in(coef_in), .in_valid(in_valid),
    .x_in(x_in), .coef_ready(rdy2), .y_valid(v2), .y_out(y2));

  typedef struct {
    bit rst_n; bit ld; int coef; bit vl; int x;
    bit ev; bit cy; int acc; bit rdy;
  } vec_t;

  vec_t vq[$];

  // Reference model state
  int mode;      // 0 idle, 1 loading, 2 running
  int hq[$];     // coefficients in load order (hq[0] = h[0])
  int hist[$];   // past accepted samples, newest first
  int ey0, ey2;
  bit ev;

  // Expected output value from a full-precision accumulator and shift amount.
  function automatic int exp_out(int acc, int sh);
    int d;
    int s;
    d = 1 << sh;
    if (acc >= 0) s = acc / d;
    else          s = -((-acc + d - 1) / d);
`ifdef FIR_SAT_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`else
    s = ((s % 256) + 256) % 256;
    if (s >= 128) s = s - 256;
`endif
    return s;
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit l, int c, bit v, int x);
    @(negedge clk);
    rst      = r;
    load_en  = l;
    coef_in  = 4'(c);
    in_valid = v;
    x_in     = 6'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic add(bit r, bit l, int c, bit v, int x, bit e, bit cy, int acc, bit rdy);
    vec_t t;
    t.rst_n = r; t.ld = l; t.coef = c; t.vl = v; t.x = x;
    t.ev = e; t.cy = cy; t.acc = acc; t.rdy = rdy;
    vq.push_back(t);
  endtask

  task automatic load5(int c0, int c1, int c2, int c3, int c4);
    int cs[5];
    cs = '{c0, c1, c2, c3, c4};
    for (int k = 0; k < 5; k++) add(1, 1, cs[k], 0, 0, 0, 0, 0, k == 4);
  endtask

  task automatic samp(int x, int acc);
    add(1, 1'b0, 0, 1, x, 1, 1, acc, 1);
  endtask

  task automatic rnd_step(bit r, bit l, int c, bit v, int x);
    int acc;
    drive(r, l, c, v, x);
    ev = 0;
    if (!r) begin
      mode = 0; hq.delete(); hist.delete(); ey0 = 0; ey2 = 0;
    end else if (l) begin
      if (mode != 1) begin hq.delete(); hist.delete(); mode = 1; end
      hq.push_back(c);
      if (hq.size() == N) mode = 2;
    end else if (mode == 2 && v) begin
      acc = hq[0] * x;
      for (int k = 1; k < N; k++) if (k - 1 < hist.size()) acc += hq[k] * hist[k-1];
      ev  = 1;
      ey0 = exp_out(acc, 0);
      ey2 = exp_out(acc, 2);
      hist.push_front(x);
      if (hist.size() > N - 1) void'(hist.pop_back());
    end
    check("rnd ready_s0", int'(rdy0), int'(mode == 2));
    check("rnd ready_s2", int'(rdy2), int'(mode == 2));
    check("rnd valid_s0", int'(v0), int'(ev));
    check("rnd valid_s2", int'(v2), int'(ev));
    check("rnd y_s0", int'($signed(y0)), ey0);
    check("rnd y_s2", int'($signed(y2)), ey2);
  endtask

  initial begin
    rst = 1'b0; load_en = 1'b0; coef_in = '0; in_valid = 1'b0; x_in = '0;

    // Reset state
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Partial load, a held cycle, then reset aborts; IDLE ignores samples
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 7, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 1, 5, 0, 1, 0, 0);
    add(1, 0, 0, 1, 5, 0, 1, 0, 0);
    add(1, 0, 0, 1, 5, 0, 1, 0, 0);
    // Pass-through coefficient set
    load5(1, 0, 0, 0, 0);
    samp(5, 5);
    add(1, 0, 0, 0, 0, 0, 1, 5, 1);
    samp(-32, -32);
    // Reload in RUN with a simultaneous sample: sample dropped, y_out held
    add(1, 1, 1, 1, 9, 0, 1, -32, 0);
    add(1, 1, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0, 0, 0, 1);
    // Impulse response from a clean history
    samp(1, 1); samp(0, 2); samp(0, 3); samp(0, 4); samp(0, 5); samp(0, 0);
    // All 7s with a hold cycle mid-load, then full-scale positive input
    add(1, 1, 7, 0, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 3, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) samp(31, 217 * k);
    // All -8s with full-scale negative input
    load5(-8, -8, -8, -8, -8);
    for (int k = 1; k <= 5; k++) samp(-32, 256 * k);
    // Floor behaviour of the arithmetic shift
    load5(3, 0, 0, 0, 0);
    samp(-5, -15);
    samp(-5, -15);
    samp(7, 21);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].ld, vq[i].coef, vq[i].vl, vq[i].x);
      check($sformatf("row%0d ready_s0", i), int'(rdy0), int'(vq[i].rdy));
      check($sformatf("row%0d ready_s2", i), int'(rdy2), int'(vq[i].rdy));
      check($sformatf("row%0d valid_s0", i), int'(v0), int'(vq[i].ev));
      check($sformatf("row%0d valid_s2", i), int'(v2), int'(vq[i].ev));
      if (vq[i].cy) begin
        check($sformatf("row%0d y_s0", i), int'($signed(y0)), exp_out(vq[i].acc, 0));
        check($sformatf("row%0d y_s2", i), int'($signed(y2)), exp_out(vq[i].acc, 2));
      end
    end

    // Randomized traffic against the reference model
    rnd_step(0, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      bit r, l, v;
      int c, x;
      r = ($urandom_range(0, 149) != 0);
      l = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      c = int'($urandom_range(0, 15)) - 8;
      v = ($urandom_range(0, 3) != 0);
      x = int'($urandom_range(0, 63)) - 32;
      rnd_step(r, l, c, v, x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
